sram_req_arbiter: RTL and testbench

- Shares one single-port on-chip SRAM macro between NUM_REQ requesters, e.g. a DMA engine and the AXI-to-SRAM bridge.
- Each requester uses a simple valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. At most one SRAM access is issued per cycle.
- The SRAM has a fixed 1-cycle read latency. The arbiter routes every response back to its originator and buffers it if the originator applies backpressure.

---
 rtl/sram_req_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
//
// Shares one single-port SRAM macro (1-cycle read latency) between NUM_REQ
// requesters. Round-robin arbitration issues at most one access per cycle,
// with zero-latency issue from the winning request. Each response goes back to
// its originator and is held stable while the originator applies backpressure.
// A requester may have at most one outstanding response.
//
// Optional feature (macro SRAM_ARB_WRITE_PRIO_EN):
//   When defined, eligible writers take precedence over eligible readers.
//   Round-robin applies among the writers. The pointer still follows the winner.
//   When undefined, arbitration is pure round-robin.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   req_valid_i   [NUM_REQ]             request valid per requester
//   req_ready_o   [NUM_REQ]             one-hot grant (request accepted)
//   req_we_i      [NUM_REQ]             1 = write, 0 = read
//   req_addr_i    [NUM_REQ*ADDR_WIDTH]  word address, slice i = requester i
//   req_wdata_i   [NUM_REQ*DATA_WIDTH]  write data
//   req_wstrb_i   [NUM_REQ*STRB_WIDTH]  byte enables
//   rsp_valid_o   [NUM_REQ]             response valid
//   rsp_ready_i   [NUM_REQ]             response accepted
//   rsp_rdata_o   [NUM_REQ*DATA_WIDTH]  read data (0 for write responses)
//   sram_en_o                           SRAM access strobe
//   sram_we_o                           SRAM write enable
//   sram_addr_o   [ADDR_WIDTH]          SRAM address
//   sram_wdata_o  [DATA_WIDTH]          SRAM write data
//   sram_wstrb_o  [STRB_WIDTH]          SRAM byte mask
//   sram_rdata_i  [DATA_WIDTH]          SRAM read data, one cycle after a read
// -----------------------------------------------------------------------------
module sram_req_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 64,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   input  logic [NUM_REQ-1:0]             req_we_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
   input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_wstrb_i,
   output logic [NUM_REQ-1:0]             rsp_valid_o,
   input  logic [NUM_REQ-1:0]             rsp_ready_i,
   output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata_o,
   output logic                           sram_en_o,
   output logic                           sram_we_o,
   output logic [ADDR_WIDTH-1:0]          sram_addr_o,
   output logic [DATA_WIDTH-1:0]          sram_wdata_o,
   output logic [STRB_WIDTH-1:0]          sram_wstrb_o,
   input  logic [DATA_WIDTH-1:0]          sram_rdata_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Round-robin search: the first candidate at or after (ptr+1) mod NUM_REQ,
   // wrapping around. Returns {found, index}.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                              input logic [PTR_W-1:0]   ptr);
      logic             found;
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] sel;
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      return {found, sel};
   endfunction

   logic [PTR_W-1:0]      ptr_r;
   logic [NUM_REQ-1:0]    pend_r;
   logic [NUM_REQ-1:0]    fresh_r;
   logic [NUM_REQ-1:0]    wflag_r;
   logic [DATA_WIDTH-1:0] hold_r [NUM_REQ];

   logic [NUM_REQ-1:0]    elig_s;
   logic [NUM_REQ-1:0]    cand_s;
   logic [NUM_REQ-1:0]    gnt_s;
   logic                  gnt_valid_s;
   logic [PTR_W-1:0]      gnt_idx_s;

   // Eligibility: a requester may issue only if its response slot frees this
   // cycle. Reset gates every grant, so sram_en_o drops as soon as rst_ni falls.
   always_comb begin
      elig_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig_s[i] = rst_ni & req_valid_i[i] & (~pend_r[i] | rsp_ready_i[i]);
      end
   end

`ifdef SRAM_ARB_WRITE_PRIO_EN
   logic [NUM_REQ-1:0] wr_elig_s;

   // Candidate set: writers only when any eligible writer exists.
   always_comb begin
      wr_elig_s = elig_s & req_we_i;
      if (|wr_elig_s) begin
         cand_s = wr_elig_s;
      end else begin
         cand_s = elig_s;
      end
   end
`else
   // Candidate set: every eligible requester.
   always_comb begin
      cand_s = elig_s;
   end
`endif

   // Winner selection from the candidate set.
   always_comb begin
      {gnt_valid_s, gnt_idx_s} = rr_pick(cand_s, ptr_r);
   end

   // One-hot grant and zero-latency SRAM command mux. Idle drives all zeros.
   always_comb begin
      gnt_s        = '0;
      sram_en_o    = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_wstrb_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_valid_s && (gnt_idx_s == PTR_W'(i))) begin
            gnt_s[i]     = 1'b1;
            sram_en_o    = 1'b1;
            sram_we_o    = req_we_i[i];
            sram_addr_o  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            sram_wdata_o = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            sram_wstrb_o = req_wstrb_i[i*STRB_WIDTH +: STRB_WIDTH];
         end else begin
            gnt_s[i] = 1'b0;
         end
      end
   end

   assign req_ready_o = gnt_s;
   assign rsp_valid_o = pend_r;

   // Response data: zero for writes, SRAM output in the fresh cycle, else held.
   always_comb begin
      rsp_rdata_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (wflag_r[i]) begin
            rsp_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end else if (fresh_r[i]) begin
            rsp_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = sram_rdata_i;
         end else begin
            rsp_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = hold_r[i];
         end
      end
   end

   // Pointer and per-requester response state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_r   <= PTR_W'(NUM_REQ - 1);
         pend_r  <= '0;
         fresh_r <= '0;
         wflag_r <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            hold_r[i] <= '0;
         end
      end else begin
         if (gnt_valid_s) begin
            ptr_r <= gnt_idx_s;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
               // A new grant also covers the case where the previous response
               // is accepted this same cycle: the slot stays occupied.
               pend_r[i]  <= 1'b1;
               fresh_r[i] <= 1'b1;
               wflag_r[i] <= req_we_i[i];
            end else if (pend_r[i] && rsp_ready_i[i]) begin
               pend_r[i]  <= 1'b0;
               fresh_r[i] <= 1'b0;
            end else if (fresh_r[i]) begin
               // Stalled in the fresh cycle: capture the SRAM output before it
               // is overwritten by the next access.
               hold_r[i]  <= wflag_r[i] ? '0 : sram_rdata_i;
               fresh_r[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

   localparam int N  = 2;
   localparam int AW = 14;
   localparam int DW = 64;
   localparam int SW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata, rsp_rdata;
   logic [N*SW-1:0] req_wstrb;
   logic            sram_en, sram_we;
   logic [AW-1:0]   sram_addr;
   logic [DW-1:0]   sram_wdata, sram_rdata;
   logic [SW-1:0]   sram_wstrb;

   always #5 clk = ~clk;

   sram_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_wstrb_o(sram_wstrb), .sram_rdata_i(sram_rdata)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] w,
                                         input logic [7:0] s);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) begin
         if (s[b]) r[b*8 +: 8] = w[b*8 +: 8];
      end
      return r;
   endfunction

   localparam logic [63:0] W10 = 64'hDEADBEEF_CAFEF00D;
   localparam logic [63:0] W20 = 64'hA5A5A5A5_A5A5A5A5;
   localparam logic [63:0] W21 = 64'h01234567_89ABCDEF;

   // Environment SRAM: 1-cycle read latency, junk on the bus when not reading.
   logic [63:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (!rst_n) begin
         mem[16] <= W10; mem[32] <= W20; mem[33] <= W21; mem[3] <= 64'd0;
         sram_rdata <= {$urandom, $urandom};
      end else begin
         if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
         else                     sram_rdata <= {$urandom, $urandom};
         if (sram_en && sram_we)  mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wstrb);
      end
   end

   // Behavioural model: outstanding-response slots, RR pointer, shadow memory.
   logic [63:0]  mmem [0:(1<<AW)-1];
   logic [N-1:0] m_pend, m_el, m_cand;
   logic [63:0]  m_data [N];
   int           m_ptr;
   int           m_g;
   int           m_idx;
   int           rsp_cnt [N] = '{default: 0};
   int           glog [$];

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_req_ready", 64'(req_ready), 64'd0);
         check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         check("rst_sram_en", 64'(sram_en), 64'd0);
         check("rst_sram_addr", 64'(sram_addr), 64'd0);
         m_pend = '0;
         m_ptr  = N - 1;
         mmem[16] = W10; mmem[32] = W20; mmem[33] = W21; mmem[3] = 64'd0;
      end else begin
         m_el   = req_valid & (~m_pend | rsp_ready);
         m_cand = m_el;
`ifdef SRAM_ARB_WRITE_PRIO_EN
         if ((m_el & req_we) != '0) m_cand = m_el & req_we;
`endif
         m_g = -1;
         for (int k = 1; k <= N; k++) begin
            m_idx = (m_ptr + k) % N;
            if (m_g < 0 && m_cand[m_idx]) m_g = m_idx;
         end
         check("cmp_req_ready", 64'(req_ready), (m_g < 0) ? 64'd0 : (64'd1 << m_g));
         check("cmp_sram_en", 64'(sram_en), (m_g < 0) ? 64'd0 : 64'd1);
         if (m_g >= 0) begin
            check("cmp_sram_we", 64'(sram_we), 64'(req_we[m_g]));
            check("cmp_sram_addr", 64'(sram_addr), 64'(req_addr[m_g*AW +: AW]));
            check("cmp_sram_wdata", sram_wdata, req_wdata[m_g*DW +: DW]);
            check("cmp_sram_wstrb", 64'(sram_wstrb), 64'(req_wstrb[m_g*SW +: SW]));
         end else begin
            check("cmp_idle_bus", {63'd0, sram_we} | 64'(sram_addr) | sram_wdata | 64'(sram_wstrb), 64'd0);
         end
         check("cmp_rsp_valid", 64'(rsp_valid), 64'(m_pend));
         for (int i = 0; i < N; i++) begin
            if (m_pend[i]) check($sformatf("cmp_rdata%0d", i), rsp_rdata[i*DW +: DW], m_data[i]);
            if (rsp_valid[i] && rsp_ready[i]) rsp_cnt[i]++;
            if (m_pend[i] && rsp_ready[i]) m_pend[i] = 1'b0;
         end
         if (m_g >= 0) begin
            m_pend[m_g] = 1'b1;
            if (req_we[m_g]) begin
               m_data[m_g] = 64'd0;
               mmem[req_addr[m_g*AW +: AW]] = merge(mmem[req_addr[m_g*AW +: AW]],
                                                    req_wdata[m_g*DW +: DW], req_wstrb[m_g*SW +: SW]);
            end else begin
               m_data[m_g] = mmem[req_addr[m_g*AW +: AW]];
            end
            m_ptr = m_g;
            glog.push_back(m_g);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      req_valid[i]          = v;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_wstrb[i*SW +: SW] = s;
   endtask

   int mark, c0, c1;

   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = '1;
      // Requests held valid during reset must not reach the SRAM.
      set_req(0, 1'b1, 1'b0, 14'h10, 64'd0, 8'h00);
      set_req(1, 1'b1, 1'b1, 14'h3, 64'd5, 8'hFF);
      @(negedge clk);
      check("reset_sram_en", 64'(sram_en), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd0);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      step();
      set_req(0, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      set_req(1, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      rst_n = 1'b1;

      // Single read
      set_req(0, 1'b1, 1'b0, 14'h10, 64'd0, 8'h00);
      @(negedge clk);
      check("rd_sram_en", 64'(sram_en), 64'd1);
      check("rd_sram_addr", 64'(sram_addr), 64'h10);
      check("rd_grant", 64'(req_ready), 64'b01);
      step();
      set_req(0, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      @(negedge clk);
      check("rd_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      check("rd_rsp_data", rsp_rdata[63:0], 64'hDEADBEEF_CAFEF00D);

      // Write then read
      step();
      set_req(1, 1'b1, 1'b1, 14'h3, 64'h11223344_55667788, 8'h0F);
      @(negedge clk);
      check("wr_grant", 64'(req_ready), 64'b10);
      check("wr_sram_we", 64'(sram_we), 64'd1);
      check("wr_sram_wstrb", 64'(sram_wstrb), 64'h0F);
      step();
      set_req(1, 1'b1, 1'b0, 14'h3, 64'd0, 8'h00);
      @(negedge clk);
      check("wr_rsp_valid", 64'(rsp_valid[1]), 64'd1);
      check("wr_rsp_zero", rsp_rdata[127:64], 64'd0);
      check("rdback_grant", 64'(req_ready), 64'b10);
      step();
      set_req(1, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      @(negedge clk);
      check("rdback_data", rsp_rdata[127:64], 64'h00000000_55667788);

      // Contention after reset: strict alternation
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mark = glog.size(); c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
      set_req(0, 1'b1, 1'b0, 14'h10, 64'd0, 8'h00);
      set_req(1, 1'b1, 1'b0, 14'h20, 64'd0, 8'h00);
      repeat (8) step();
      set_req(0, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      set_req(1, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      step();
      check("cont_grants", 64'(glog.size() - mark), 64'd8);
      for (int k = 0; k < 8; k++) begin
         if (mark + k < glog.size()) check($sformatf("cont_order%0d", k), 64'(glog[mark+k]), 64'(k % 2));
      end
      check("cont_rsp0", 64'(rsp_cnt[0] - c0), 64'd4);
      check("cont_rsp1", 64'(rsp_cnt[1] - c1), 64'd4);

      // Backpressure: req0 stalled, req1 streams
      rsp_ready[0] = 1'b0;
      set_req(0, 1'b1, 1'b0, 14'h20, 64'd0, 8'h00);
      set_req(1, 1'b1, 1'b0, 14'h10, 64'd0, 8'h00);
      @(negedge clk);
      check("bp_first_grant", 64'(req_ready), 64'b01);
      step();
      set_req(0, 1'b1, 1'b0, 14'h21, 64'd0, 8'h00);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("bp_skip%0d", k), 64'(req_ready), 64'b10);
         check($sformatf("bp_hold%0d", k), rsp_rdata[63:0], W20);
         check($sformatf("bp_valid%0d", k), 64'(rsp_valid[0]), 64'd1);
         step();
      end
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      check("bp_regrant", 64'(req_ready), 64'b01);
      check("bp_hold_accept", rsp_rdata[63:0], W20);
      step();
      set_req(0, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      set_req(1, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      @(negedge clk);
      check("bp_next_data", rsp_rdata[63:0], W21);

      // Reset mid-flight with requests still valid
      step();
      set_req(0, 1'b1, 1'b0, 14'h10, 64'd0, 8'h00);
      set_req(1, 1'b1, 1'b0, 14'h20, 64'd0, 8'h00);
      @(negedge clk);
      check("mid_grant", 64'(req_ready), 64'b10);
      step();
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid_sram_en", 64'(sram_en), 64'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_after_grant", 64'(req_ready), 64'b01);

      // Direction mix: req0 read, req1 write
      step();
      set_req(1, 1'b1, 1'b1, 14'h5, 64'h0BADF00D_12345678, 8'hFF);
      @(negedge clk);
      check("mix_first", 64'(req_ready), 64'b10);
      step();
      @(negedge clk);
`ifdef SRAM_ARB_WRITE_PRIO_EN
      check("mix_second", 64'(req_ready), 64'b10);
`else
      check("mix_second", 64'(req_ready), 64'b01);
`endif
      step();
      set_req(0, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      set_req(1, 1'b0, 1'b0, 14'h0, 64'd0, 8'h00);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
